// File: rtl/memory_arbiter.sv
// Two-requester RAM arbiter: data port has priority over instruction fetch.
// Optional starvation guard enabled by defining MEM_ARB_FAIRNESS_EN.
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  // state | meaning
  // IDLE  | no RAM strobes, pick next requester
  // DSERV | data load/store presented to RAM
  // ISERV | instruction fetch presented to RAM
  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_starve_limit
    $error("memory_arbiter: STARVE_LIMIT must be in 1..7");
  end

  state_t state, next_state;
  logic   dreq;
  logic   fair_force;

  assign dreq = dREN | dWEN;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [2:0] STARVE_LIM3 = 3'(STARVE_LIMIT);

  logic [2:0] streak;
  logic       d_done;
  logic       i_done;

  assign d_done     = (state == DSERV) && dreq && (ramstate == RAM_ACCESS);
  assign i_done     = (state == ISERV) && iREN && (ramstate == RAM_ACCESS);
  assign fair_force = iREN && (streak >= STARVE_LIM3);

  // Counts consecutive data completions; saturates so it never wraps back below the limit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      streak <= 3'd0;
    end else if (i_done) begin
      streak <= 3'd0;
    end else if (d_done && streak != 3'd7) begin
      streak <= streak + 3'd1;
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes follow the live request so a withdrawn request drops them in the same cycle.
  always_comb begin
    next_state = state;
    iwait      = iREN;
    dwait      = dreq;
    iload      = 32'd0;
    dload      = 32'd0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = 32'd0;
    ramstore   = 32'd0;
    merr       = 1'b0;
    case (state)
      IDLE: begin
        if (fair_force) begin
          next_state = ISERV;
        end else if (dreq) begin
          next_state = DSERV;
        end else if (iREN) begin
          next_state = ISERV;
        end
      end
      DSERV: begin
        if (!dreq) begin
          next_state = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == RAM_ACCESS) begin
            dwait      = 1'b0;
            dload      = dWEN ? 32'd0 : ramload;
            next_state = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            dwait      = 1'b0;
            merr       = 1'b1;
            next_state = IDLE;
          end
        end
      end
      ISERV: begin
        if (!iREN) begin
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            iwait      = 1'b0;
            iload      = ramload;
            next_state = IDLE;
          end else if (ramstate == RAM_ERROR) begin
            iwait      = 1'b0;
            merr       = 1'b1;
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus a randomized
// run against a requester-level reference model.
module tb_memory_arbiter;

  localparam int LIMIT = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int n_checks = 0;
  int n_fail   = 0;

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .merr(merr)
  );

  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    iREN = 1; dREN = 0; dWEN = 1; iaddr = 32'h11; daddr = 32'h22; dstore = 32'h33;
    ramstate = 2'd2; ramload = $urandom;
    @(posedge CLK); #1;
    @(negedge CLK);
    n_checks++;
    if ({ramREN, ramWEN, merr} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes got %b want 000", {ramREN, ramWEN, merr});
    end
    n_checks++;
    if (ramaddr !== 0 || ramstore !== 0) begin
      n_fail++; $display("FAIL reset_addr got %h/%h want 0/0", ramaddr, ramstore);
    end
    n_checks++;
    if (iload !== 0 || dload !== 0) begin
      n_fail++; $display("FAIL reset_loads got %h/%h want 0/0", iload, dload);
    end
    n_checks++;
    if ({iwait, dwait} !== 2'b11) begin
      n_fail++; $display("FAIL reset_waits got %b want 11", {iwait, dwait});
    end
    RST = 1'b0;
    clear_inputs();
  endtask

  task automatic test_load();
    do_reset();
    dREN = 1; daddr = 32'h40; ramstate = 2'd0;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || dwait !== 1'b1) begin
      n_fail++; $display("FAIL load_idle got ren=%b dwait=%b want 0 1", ramREN, dwait);
    end
    @(posedge CLK); #1;
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin
      n_fail++; $display("FAIL load_strobe got ren=%b addr=%h want 1 40", ramREN, ramaddr);
    end
    n_checks++;
    if (dwait !== 1'b0 || dload !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL load_data got dwait=%b dload=%h want 0 deadbeef", dwait, dload);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || dload !== 32'd0) begin
      n_fail++; $display("FAIL load_back_idle got ren=%b dload=%h want 0 0", ramREN, dload);
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    int wen_cnt = 0;
    do_reset();
    iREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h55AA; iaddr = 32'h200;
    ramstate = 2'd1; ramload = 32'h12345678;
    @(negedge CLK);
    n_checks++;
    if (ramWEN !== 1'b0 || {iwait, dwait} !== 2'b11) begin
      n_fail++; $display("FAIL cont_idle got wen=%b waits=%b want 0 11", ramWEN, {iwait, dwait});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
      ramstate = (k < 2) ? 2'd1 : 2'd2;
      @(negedge CLK);
      if (ramWEN === 1'b1) wen_cnt++;
      n_checks++;
      if (ramaddr !== 32'h100 || ramstore !== 32'h55AA || iwait !== 1'b1 || dwait !== (k < 2)) begin
        n_fail++;
        $display("FAIL cont_store k=%0d got addr=%h st=%h iw=%b dw=%b want 100 55aa 1 %b",
                 k, ramaddr, ramstore, iwait, dwait, (k < 2));
      end
    end
    n_checks++;
    if (wen_cnt !== 3) begin
      n_fail++; $display("FAIL cont_wen_cycles got %0d want 3", wen_cnt);
    end
    @(posedge CLK); #1;
    dWEN = 0;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || iwait !== 1'b1) begin
      n_fail++; $display("FAIL cont_gap got ren=%b wen=%b iw=%b want 0 0 1", ramREN, ramWEN, iwait);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h200 || iwait !== 1'b0 || iload !== 32'h12345678) begin
      n_fail++;
      $display("FAIL cont_fetch got ren=%b addr=%h iw=%b iload=%h want 1 200 0 12345678",
               ramREN, ramaddr, iwait, iload);
    end
    clear_inputs();
  endtask

  task automatic test_error();
    do_reset();
    iREN = 1; iaddr = 32'h80; ramstate = 2'd3; ramload = 32'hCAFEF00D;
    @(negedge CLK);
    n_checks++;
    if (merr !== 1'b0 || iwait !== 1'b1) begin
      n_fail++; $display("FAIL err_idle got merr=%b iw=%b want 0 1", merr, iwait);
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    n_checks++;
    if (merr !== 1'b1 || iwait !== 1'b0 || iload !== 32'd0) begin
      n_fail++; $display("FAIL err_pulse got merr=%b iw=%b iload=%h want 1 0 0", merr, iwait, iload);
    end
    @(posedge CLK); #1;
    iREN = 0;
    @(negedge CLK);
    n_checks++;
    if (merr !== 1'b0) begin
      n_fail++; $display("FAIL err_one_cycle got merr=%b want 0", merr);
    end
    clear_inputs();
  endtask

  task automatic test_fairness();
    int d_done = 0;
    int d_before_i = -1;
    int exp_before;
    do_reset();
    dREN = 1; iREN = 1; ramstate = 2'd2;
    for (int c = 0; c < 24; c++) begin
      ramload = $urandom;
      @(negedge CLK);
      if (!iwait && d_before_i < 0) d_before_i = d_done;
      if (!dwait) d_done++;
      @(posedge CLK); #1;
    end
`ifdef MEM_ARB_FAIRNESS_EN
    exp_before = LIMIT;
`else
    exp_before = -1;
`endif
    n_checks++;
    if (d_before_i !== exp_before) begin
      n_fail++; $display("FAIL fairness data_before_fetch got %0d want %0d", d_before_i, exp_before);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    dREN = 1; daddr = 32'h44; ramstate = 2'd1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (dwait !== 1'b1 || merr !== 1'b0 || ramREN !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_busy got dw=%b merr=%b ren=%b want 1 0 1", dwait, merr, ramREN);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 0 || dwait !== 1'b1 || merr !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle got ren=%b wen=%b addr=%h dw=%b merr=%b want 0 0 0 1 0",
               ramREN, ramWEN, ramaddr, dwait, merr);
    end
    clear_inputs();
  endtask

  task automatic test_withdraw();
    do_reset();
    dREN = 1; daddr = 32'h60; ramstate = 2'd1;
    @(posedge CLK); #1;
    dREN = 0;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || dload !== 32'd0 || merr !== 1'b0) begin
      n_fail++; $display("FAIL withdraw_drop got ren=%b dload=%h merr=%b want 0 0 0", ramREN, dload, merr);
    end
    @(posedge CLK); #1;
    ramstate = 2'd2; ramload = 32'hA5A5A5A5;
    @(negedge CLK);
    n_checks++;
    if (ramREN !== 1'b0 || dload !== 32'd0) begin
      n_fail++; $display("FAIL withdraw_idle got ren=%b dload=%h want 0 0", ramREN, dload);
    end
    clear_inputs();
  endtask

  // Model tracks only who is being served (0 none, 1 data, 2 fetch) and the data streak.
  task automatic test_random();
    int srv = 0, streak = 0, nsrv, nstreak;
    logic dreq, e_ren, e_wen, e_iw, e_dw, e_merr;
    logic [31:0] e_addr, e_store, e_il, e_dl;
    bit fair;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      RST = ($urandom_range(0, 39) == 0);
      iREN = ($urandom_range(0, 3) != 0);
      dREN = $urandom_range(0, 1);
      dWEN = ($urandom_range(0, 2) == 0);
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      ramstate = 2'($urandom_range(0, 3));
      @(negedge CLK);
      dreq = dREN | dWEN;
      e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0; e_il = 0; e_dl = 0; e_merr = 0;
      e_iw = iREN; e_dw = dreq;
      if (srv == 1 && dreq) begin
        e_addr = daddr;
        if (dWEN) begin e_wen = 1; e_store = dstore; end else e_ren = 1;
        if (ramstate >= 2) e_dw = 0;
        if (ramstate == 2 && !dWEN) e_dl = ramload;
        if (ramstate == 3) e_merr = 1;
      end
      if (srv == 2 && iREN) begin
        e_ren = 1; e_addr = iaddr;
        if (ramstate >= 2) e_iw = 0;
        if (ramstate == 2) e_il = ramload;
        if (ramstate == 3) e_merr = 1;
      end
      n_checks++;
      if ({ramREN, ramWEN, merr} !== {e_ren, e_wen, e_merr}) begin
        n_fail++; $display("FAIL rand_strobes c=%0d got %b want %b", c, {ramREN, ramWEN, merr}, {e_ren, e_wen, e_merr});
      end
      n_checks++;
      if (ramaddr !== e_addr || ramstore !== e_store) begin
        n_fail++; $display("FAIL rand_addr c=%0d got %h/%h want %h/%h", c, ramaddr, ramstore, e_addr, e_store);
      end
      n_checks++;
      if ({iwait, dwait} !== {e_iw, e_dw}) begin
        n_fail++; $display("FAIL rand_waits c=%0d got %b want %b", c, {iwait, dwait}, {e_iw, e_dw});
      end
      n_checks++;
      if (iload !== e_il || dload !== e_dl) begin
        n_fail++; $display("FAIL rand_loads c=%0d got %h/%h want %h/%h", c, iload, dload, e_il, e_dl);
      end
      nsrv = srv; nstreak = streak;
`ifdef MEM_ARB_FAIRNESS_EN
      fair = iREN && (streak >= LIMIT);
`else
      fair = 1'b0;
`endif
      if (srv == 0) nsrv = fair ? 2 : dreq ? 1 : iREN ? 2 : 0;
      else if (srv == 1) begin
        if (!dreq || ramstate >= 2) nsrv = 0;
        if (dreq && ramstate == 2 && streak < 7) nstreak = streak + 1;
      end else begin
        if (!iREN || ramstate >= 2) nsrv = 0;
        if (iREN && ramstate == 2) nstreak = 0;
      end
      if (RST) begin nsrv = 0; nstreak = 0; end
      @(posedge CLK); #1;
      srv = nsrv; streak = nstreak;
    end
    RST = 0;
    clear_inputs();
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    test_reset();
    test_load();
    test_contention();
    test_error();
    test_fairness();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, meaning consecutive data grants allowed before a pending instruction fetch is forced through (range 1..7).
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  reset: synchronous, active-high.
REQ-004 iREN  input  1  instruction fetch request.
REQ-005 iaddr  input  32  instruction word address.
REQ-006 dREN  input  1  data load request.
REQ-007 dWEN  input  1  data store request.
REQ-008 daddr  input  32  data address.
REQ-009 dstore  input  32  store data.
REQ-010 iwait  output  1  high while iREN is pending and not completing this cycle.
REQ-011 dwait  output  1  high while dREN|dWEN is pending and not completing this cycle.
REQ-012 iload  output  32  fetch data, valid in the iREN completion cycle; 0 otherwise.
REQ-013 dload  output  32  load data, valid in the dREN completion cycle; 0 otherwise.
REQ-014 ramREN  output  1  RAM read strobe.
REQ-015 ramWEN  output  1  RAM write strobe.
REQ-016 ramaddr  output  32  RAM address.
REQ-017 ramstore  output  32  RAM write data.
REQ-018 ramload  input  32  RAM read data.
REQ-019 ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-020 merr  output  1  one-cycle pulse when a transaction ends on ERROR.

Function
REQ-021 FSM states: IDLE, DSERV, ISERV; exactly one active.
REQ-022 IDLE: no RAM strobes; next state DSERV if dREN|dWEN, else ISERV if iREN, else IDLE (data priority).
REQ-023 Minimum latency: request seen in IDLE at cycle N completes no earlier than cycle N+1.
REQ-024 DSERV: ramaddr=daddr; dWEN=1 drives ramWEN=1, ramstore=dstore, ramREN=0; otherwise ramREN=1; dWEN wins if dREN and dWEN both high.
REQ-025 ISERV: ramREN=1, ramaddr=iaddr, ramWEN=0, ramstore=0.
REQ-026 Completion: ramstate==ACCESS in a service state deasserts that requester's wait that cycle, drives iload/dload=ramload for reads, next state IDLE.
REQ-027 ramstate FREE or BUSY in a service state: hold state and strobes; wait stays high.
REQ-028 ramstate ERROR in a service state: wait deasserted, load data 0, merr=1 for that cycle, next state IDLE.
REQ-029 Request withdrawn while in its service state: strobes drop same cycle (combinational), next state IDLE, no completion, no merr.
REQ-030 Non-served requester's wait stays high while its request is asserted.
REQ-031 Data-streak counter (3 bits): increments on each data completion, clears on instruction completion; saturates at 7.

Reset
REQ-032 RST high at a rising edge: state=IDLE, streak counter=0, effective next cycle regardless of in-flight transaction (abandoned, no completion).
REQ-033 While in IDLE after reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, merr=0; iwait=iREN, dwait=dREN|dWEN.

Configuration
REQ-034 Macro MEM_ARB_FAIRNESS_EN defined: in IDLE, if iREN and streak counter >= STARVE_LIMIT, next state ISERV even with data pending.
REQ-035 MEM_ARB_FAIRNESS_EN undefined: strict data priority per REQ-022; streak counter may be omitted.

Verification
REQ-036 Load: dREN=1, daddr=0x40, ramstate=ACCESS from 2nd cycle, ramload=0xDEADBEEF -> DSERV entered, ramREN=1 ramaddr=0x40, dwait low and dload=0xDEADBEEF in that cycle, IDLE next.
REQ-037 Contention: iREN and dWEN both high from IDLE, ramstate BUSY 2 cycles then ACCESS -> data store served first (ramWEN=1 3 cycles), iwait high throughout, then ISERV.
REQ-038 Error: iREN=1, ramstate=ERROR in ISERV -> iwait low, iload=0, merr pulses one cycle.
REQ-039 Fairness (macro defined, STARVE_LIMIT=4): dREN held high, iREN high, RAM always ACCESS -> 4 data completions then one instruction completion; macro undefined -> iwait never drops.
REQ-040 Reset mid-transaction: RST asserted in DSERV with ramstate BUSY -> next cycle IDLE, all RAM strobes 0, no dwait drop, no merr.
REQ-041 Withdraw: dREN dropped in DSERV before ACCESS -> ramREN low same cycle, IDLE next, dload stays 0.
